// File: rtl/mem_bus_arbiter.sv
// Two-to-one memory port arbiter: instruction fetch and LSU share one
// single-ported bus. Responses come back in order; a small source-ID FIFO
// remembers who issued each accepted request so the response is routed back.
//
// state  | meaning
// IDLE   | free to pick a winner this cycle (data priority, starvation guard)
// LOCK_I | instr request presented but not yet accepted; selection frozen
// LOCK_D | data request presented but not yet accepted; selection frozen
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        protocol_err
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  localparam logic [2:0] MAX_CNT    = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] PTR_LAST   = 2'(MAX_OUTSTANDING - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] count;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [3:0] src_fifo;
  logic [3:0] starve;
  logic       sel_i;
  logic       sel_d;
  logic       push;
  logic       pop;
  logic       head_d;

  // Winner selection; frozen while locked, blocked when the FIFO is full.
  // Reset also silences the selection so outputs go quiet immediately.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (state)
      LOCK_I: sel_i = 1'b1;
      LOCK_D: sel_d = 1'b1;
      default: begin
        if (count != MAX_CNT) begin
          if (data_req && !(instr_req && starve == STARVE_MAX)) sel_d = 1'b1;
          else if (instr_req)                                    sel_i = 1'b1;
        end
      end
    endcase
    if (!reset_n) begin
      sel_i = 1'b0;
      sel_d = 1'b0;
    end
  end

  // Downstream request fields muxed from the winner; zero when idle.
  always_comb begin
    mem_req   = sel_i | sel_d;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (sel_d) begin
      mem_wr    = data_wr;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_be    = data_be;
    end else if (sel_i) begin
      mem_addr  = instr_addr;
      mem_be    = 4'hF;
    end
  end

  assign push      = mem_req & mem_gnt;
  assign instr_gnt = push & sel_i;
  assign data_gnt  = push & sel_d;

  assign pop    = reset_n & mem_valid & (count != 3'd0);
  assign head_d = src_fifo[rd_ptr];

  assign instr_valid = pop & ~head_d;
  assign data_valid  = pop & head_d;
  assign instr_rdata = reset_n ? mem_rdata : 32'h0;
  assign data_rdata  = reset_n ? mem_rdata : 32'h0;
  assign instr_err   = reset_n & mem_err;
  assign data_err    = reset_n & mem_err;

  // Lock onto the presented source until the bus accepts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (mem_gnt) begin
      state <= IDLE;
    end else if (sel_d) begin
      state <= LOCK_D;
    end else if (sel_i) begin
      state <= LOCK_I;
    end
  end

  // Source-ID FIFO: push on accept, pop on response, pointers wrap at depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 3'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      src_fifo <= 4'h0;
    end else begin
      if (push) begin
        src_fifo[wr_ptr] <= sel_d;
        wr_ptr           <= (wr_ptr == PTR_LAST) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? 2'd0 : rd_ptr + 2'd1;
      end
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end

  // Count data wins while fetch waits; fetch is forced through at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= 4'd0;
    end else if (!instr_req || instr_gnt) begin
      starve <= 4'd0;
    end else if (data_gnt && starve != STARVE_MAX) begin
      starve <= starve + 4'd1;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_err <= 1'b0;
    end else if (mem_valid && count == 3'd0) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a queue model.
module tb_mem_bus_arbiter;

  localparam int MAX   = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.MAX_OUTSTANDING(MAX), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
    .data_valid(data_valid), .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding sources, frozen selection, starve tally.
  bit q[$];
  int lock_src = -1;
  int starve_m = 0;
  bit perr_m = 1'b0;

  always @(negedge clk) begin
    int n, win;
    bit gnt, resp, hd, dummy;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_wr;
    if (!reset_n) begin
      q.delete();
      lock_src = -1;
      starve_m = 0;
      perr_m   = 1'b0;
    end else begin
      n = q.size();
      if (lock_src >= 0)                                  win = lock_src;
      else if (n == MAX)                                  win = -1;
      else if (data_req && !(instr_req && starve_m == LIMIT)) win = 1;
      else if (instr_req)                                 win = 0;
      else                                                win = -1;
      e_addr  = (win == 1) ? data_addr  : (win == 0) ? instr_addr : 32'h0;
      e_wdata = (win == 1) ? data_wdata : 32'h0;
      e_wr    = (win == 1) ? data_wr    : 1'b0;
      e_be    = (win == 1) ? data_be    : (win == 0) ? 4'hF : 4'h0;
      gnt  = (win >= 0) && mem_gnt;
      resp = mem_valid && n > 0;
      hd   = (n > 0) ? q[0] : 1'b0;
      cmp("m_mem_req",   32'(mem_req),   32'(win >= 0));
      cmp("m_mem_wr",    32'(mem_wr),    32'(e_wr));
      cmp("m_mem_addr",  mem_addr,       e_addr);
      cmp("m_mem_wdata", mem_wdata,      e_wdata);
      cmp("m_mem_be",    32'(mem_be),    32'(e_be));
      cmp("m_instr_gnt", 32'(instr_gnt), 32'(gnt && win == 0));
      cmp("m_data_gnt",  32'(data_gnt),  32'(gnt && win == 1));
      cmp("m_instr_valid", 32'(instr_valid), 32'(resp && !hd));
      cmp("m_data_valid",  32'(data_valid),  32'(resp && hd));
      cmp("m_protocol_err", 32'(protocol_err), 32'(perr_m));
      if (resp && !hd) begin
        cmp("m_instr_rdata", instr_rdata, mem_rdata);
        cmp("m_instr_err", 32'(instr_err), 32'(mem_err));
      end
      if (resp && hd) begin
        cmp("m_data_rdata", data_rdata, mem_rdata);
        cmp("m_data_err", 32'(data_err), 32'(mem_err));
      end
      if (resp) dummy = q.pop_front();
      if (gnt) q.push_back(win == 1);
      if (mem_valid && n == 0) perr_m = 1'b1;
      lock_src = ((win >= 0) && !mem_gnt) ? win : -1;
      if (!instr_req || (gnt && win == 0)) starve_m = 0;
      else if (gnt && win == 1 && starve_m < LIMIT) starve_m++;
    end
  end

  task automatic idle_in();
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_be = 4'h0;
    mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ig, dg;
    reset_n = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    cmp("rst_mem_req", 32'(mem_req), 32'h0);
    cmp("rst_protocol_err", 32'(protocol_err), 32'h0);
    cmp("rst_gnt", 32'({instr_gnt, data_gnt}), 32'h0);

    // spurious response at idle
    tick(); idle_in(); mem_valid = 1'b1; mem_rdata = 32'h1234; #1;
    cmp("spur_valid", 32'({instr_valid, data_valid}), 32'h0);
    tick(); idle_in(); #1;
    cmp("spur_protocol_err", 32'(protocol_err), 32'h1);

    // single fetch
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1; #1;
    cmp("fetch_gnt", 32'(instr_gnt), 32'h1);
    cmp("fetch_addr", mem_addr, 32'h100);
    cmp("fetch_be", 32'(mem_be), 32'hF);
    tick(); idle_in(); #1;
    tick(); idle_in(); mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    cmp("fetch_valid", 32'(instr_valid), 32'h1);
    cmp("fetch_rdata", instr_rdata, 32'hDEADBEEF);
    cmp("fetch_data_valid", 32'(data_valid), 32'h0);

    // contention: D D D D I D, count held at 1 by push+pop each cycle
    for (int c = 0; c < 6; c++) begin
      tick(); idle_in();
      instr_req = 1'b1; instr_addr = 32'h1000;
      data_req = 1'b1; data_addr = 32'h2000 + 32'(c * 4); data_be = 4'h3;
      mem_gnt = 1'b1; mem_valid = (c > 0); mem_rdata = $urandom;
      #1;
      cmp("cont_data_gnt", 32'(data_gnt), 32'(c != 4));
      cmp("cont_instr_gnt", 32'(instr_gnt), 32'(c == 4));
    end
    tick(); idle_in(); mem_valid = 1'b1; mem_rdata = 32'hA5A5A5A5; #1;
    cmp("cont_drain_dvalid", 32'(data_valid), 32'h1);
    tick(); idle_in(); #1;

    // outstanding full
    tick(); idle_in(); data_req = 1'b1; data_addr = 32'h200; data_be = 4'hF; mem_gnt = 1'b1; #1;
    cmp("full_dgnt", 32'(data_gnt), 32'h1);
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h104; mem_gnt = 1'b1; #1;
    cmp("full_igntb", 32'(instr_gnt), 32'h1);
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h108; mem_gnt = 1'b1; #1;
    cmp("full_mem_req", 32'(mem_req), 32'h0);
    cmp("full_igntc", 32'(instr_gnt), 32'h0);
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h108; mem_gnt = 1'b1;
    mem_valid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h55; #1;
    cmp("full_dvalid", 32'(data_valid), 32'h1);
    cmp("full_derr", 32'(data_err), 32'h1);
    cmp("full_ivalid", 32'(instr_valid), 32'h0);
    cmp("full_req_still0", 32'(mem_req), 32'h0);
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h108; mem_gnt = 1'b1; #1;
    cmp("full_req_back", 32'(mem_req), 32'h1);
    cmp("full_addr_back", mem_addr, 32'h108);
    cmp("full_ignt_back", 32'(instr_gnt), 32'h1);
    for (int c = 0; c < 2; c++) begin
      tick(); idle_in(); mem_valid = 1'b1; mem_rdata = 32'h11 + 32'(c); #1;
      cmp("full_drain_ivalid", 32'(instr_valid), 32'h1);
    end
    tick(); idle_in(); #1;

    // lock: instr presented, not accepted for 3 cycles, data arrives meanwhile
    for (int c = 0; c < 4; c++) begin
      tick(); idle_in();
      instr_req = 1'b1; instr_addr = 32'h300;
      if (c > 0) begin data_req = 1'b1; data_addr = 32'h400; data_be = 4'hF; end
      mem_gnt = (c == 3);
      #1;
      cmp("lock_addr", mem_addr, 32'h300);
      cmp("lock_dgnt", 32'(data_gnt), 32'h0);
      cmp("lock_ignt", 32'(instr_gnt), 32'(c == 3));
    end
    tick(); idle_in(); data_req = 1'b1; data_addr = 32'h400; data_be = 4'hF; mem_gnt = 1'b1; #1;
    cmp("lock_after_dgnt", 32'(data_gnt), 32'h1);
    cmp("lock_after_addr", mem_addr, 32'h400);
    tick(); idle_in(); mem_valid = 1'b1; #1;
    cmp("lock_resp_i", 32'(instr_valid), 32'h1);
    tick(); idle_in(); mem_valid = 1'b1; #1;
    cmp("lock_resp_d", 32'(data_valid), 32'h1);
    tick(); idle_in(); #1;

    // reset asserted mid-lock
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h500; #1;
    tick(); idle_in(); instr_req = 1'b1; instr_addr = 32'h500;
    data_req = 1'b1; data_addr = 32'h600; #1;
    cmp("mid_lock_addr", mem_addr, 32'h500);
    cmp("mid_lock_perr", 32'(protocol_err), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    cmp("arst_req", 32'(mem_req), 32'h0);
    cmp("arst_addr", mem_addr, 32'h0);
    cmp("arst_be", 32'(mem_be), 32'h0);
    cmp("arst_gnt", 32'({instr_gnt, data_gnt}), 32'h0);
    cmp("arst_valid", 32'({instr_valid, data_valid}), 32'h0);
    cmp("arst_perr", 32'(protocol_err), 32'h0);
    tick(); idle_in();
    tick(); reset_n = 1'b1; #1;
    cmp("rel_perr", 32'(protocol_err), 32'h0);
    cmp("rel_req", 32'(mem_req), 32'h0);

    // random traffic; requesters hold until granted
    ig = 1'b0; dg = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ig = instr_gnt; dg = data_gnt;
      @(posedge clk);
      #1;
      if (!instr_req || ig) begin
        instr_req  = ($urandom_range(0, 2) != 0);
        instr_addr = $urandom;
      end
      if (!data_req || dg) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = 1'($urandom_range(0, 1));
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_be    = 4'($urandom_range(0, 15));
      end
      mem_gnt   = ($urandom_range(0, 2) != 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      mem_err   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the core's instruction-fetch port and its data (LSU) port.
- Sits between riscv_core's instr_*/data_* interfaces and a single-ported memory/bus.
- Uses a request/grant/valid handshake with in-order responses.
- Tracks outstanding transactions in a source-ID FIFO so each response returns to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2: max granted-but-unanswered transactions (1..4).
- STARVE_LIMIT, 4: consecutive data grants allowed while instr_req is waiting before instr is forced to win (1..15).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- instr_req  input  1  fetch request, held until instr_gnt
- instr_addr  input  32  fetch address
- instr_gnt  output  1  fetch request accepted this cycle
- instr_valid  output  1  fetch response valid
- instr_rdata  output  32  fetch read data
- instr_err  output  1  fetch response error
- data_req  input  1  LSU request, held until data_gnt
- data_wr  input  1  1=write, 0=read
- data_addr  input  32  LSU address
- data_wdata  input  32  write data
- data_be  input  4  byte enables
- data_gnt  output  1  LSU request accepted
- data_valid  output  1  LSU response valid
- data_rdata  output  32  LSU read data
- data_err  output  1  LSU response error
- mem_req  output  1  downstream request
- mem_wr  output  1  downstream write
- mem_addr  output  32  downstream address
- mem_wdata  output  32  downstream write data
- mem_be  output  4  downstream byte enables
- mem_gnt  input  1  downstream accept
- mem_valid  input  1  downstream response valid
- mem_rdata  input  32  downstream read data
- mem_err  input  1  downstream response error
- protocol_err  output  1  sticky: mem_valid seen with no outstanding transaction

Behaviour:
- Reset (async, reset_n=0):
  - FSM to IDLE; FIFO empty (count=0); starve counter 0; protocol_err=0.
  - All outputs are combinational from state, so all gnt/valid/req outputs are 0 and buses are 0.
- FSM states: IDLE, LOCK_I, LOCK_D.
- IDLE:
  - If count==MAX_OUTSTANDING: mem_req=0, no grant.
  - Else choose a source the same cycle (combinational):
    - data wins if data_req, unless (instr_req && starve==STARVE_LIMIT).
    - Otherwise instr wins if instr_req.
  - mem_req=1 and the mem_* fields are muxed from the winner.
  - On mem_gnt=1: stay IDLE. Otherwise go to LOCK_I or LOCK_D.
- LOCK_x:
  - Selection is frozen and mem_req=1 with source x fields, regardless of the other requester.
  - On mem_gnt: go to IDLE.
  - Count cannot reach full while locked, because entry to LOCK requires count<MAX.
- Read/write fields:
  - Instr transactions drive mem_wr=0, mem_be=4'hF, mem_wdata=0.
  - mem_* fields are 0 when mem_req=0.
- Grant routing: instr_gnt = mem_req & mem_gnt & sel==I; data_gnt likewise. Combinational pass-through, zero latency.
- FIFO:
  - 1-bit source ID (0=I, 1=D), depth MAX_OUTSTANDING.
  - Push on mem_req&mem_gnt. Pop on mem_valid when count>0.
  - Simultaneous push and pop: count unchanged.
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Response routing (combinational):
  - instr_valid = mem_valid & count>0 & head==I; data_valid likewise.
  - rdata and err are passed to both requesters; only the valid for the selected source asserts.
  - Write responses also assert data_valid.
- Spurious response: mem_valid with count==0 is dropped, no valid asserted, protocol_err set to 1 until reset.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on a data grant while instr_req=1.
  - Clears on an instr grant or whenever instr_req=0.
- mem_err has no effect on arbitration; it is only forwarded.
- The requester must hold its req/fields stable until its gnt. Behaviour is undefined if it does not; no checking is done.

Test Plan:
- Single fetch: instr_req addr 0x100, mem_gnt same cycle, mem_valid 2 cycles later with rdata 0xDEADBEEF -> instr_gnt same cycle, instr_valid=1 with 0xDEADBEEF, data_valid=0, count back to 0.
- Contention: instr_req and data_req both high, STARVE_LIMIT=4, mem_gnt always 1 -> data granted cycles 0-3, instr granted cycle 4, data again cycle 5.
- Lock: instr selected alone with mem_gnt=0 for 3 cycles, data_req rises cycle 1 -> mem_addr stays instr_addr until gnt, data_gnt=0 throughout the lock.
- Outstanding full: MAX_OUTSTANDING=2, grant data read at 0x200 then instr fetch, no responses -> mem_req=0 with a third request pending. First mem_valid (err=1) -> data_valid=1, data_err=1; next cycle mem_req=1.
- Simultaneous push/pop at count=1 -> count stays 1; in-order routing checked over a 20-transaction random sequence.
- Spurious mem_valid at reset idle -> no valid outputs, protocol_err=1. Assert reset_n=0 mid-lock -> all outputs 0 asynchronously and protocol_err cleared.
